// File: rtl/majority_pkg.sv
// Shared definitions for the majority voter slice.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package majority_pkg;

    // Result driven on an exact even split unless overridden per instance.
    localparam logic TIE_VAL_DEFAULT = 1'b0;

    // Bits needed to hold a ones-count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/majority_popcount.sv
// Purely combinational count of set bits across the N voter inputs.
// Latency: 0 cycles (combinational).
// Backpressure: none; output follows the input continuously.
module majority_popcount
    import majority_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]            inp,
    output logic [$clog2(N+1)-1:0]  cnt
);

    localparam int CW = cnt_width(N);

    // Ripple sum of the input bits; N is small so a linear adder chain is fine.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CW'(inp[i]);
        end
    end

endmodule

// File: rtl/majority_voter.sv
// Registered N-input majority vote with ones-count, unanimity and tie flags.
// Latency: 1 cycle from accepted in_valid to out_valid; one vote per cycle.
// Backpressure: none; every in_valid cycle is accepted, outputs hold when idle.
module majority_voter
    import majority_pkg::*;
#(
    parameter int   N       = 3,
    parameter logic TIE_VAL = TIE_VAL_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            inp,
    input  logic                    in_valid,
    output logic                    out,
    output logic                    out_valid,
    output logic [$clog2(N+1)-1:0]  ones_cnt,
    output logic                    unanimous,
    output logic                    tie
);

    localparam int             CW   = cnt_width(N);
    // Floor of N/2: a strict majority needs more ones than this.
    localparam logic [CW-1:0]  HALF = CW'(N / 2);
    localparam logic [CW-1:0]  ALL  = CW'(N);
    localparam bit             EVEN = ((N % 2) == 0);

    logic [CW-1:0] cnt;
    logic          is_tie;
    logic          vote;
    logic          all_same;

    majority_popcount #(
        .N   (N)
    ) u_popcount (
        .inp (inp),
        .cnt (cnt)
    );

    // Decide the vote and status flags from the current ones-count.
    always_comb begin
        is_tie   = EVEN && (cnt == HALF);
        vote     = is_tie ? TIE_VAL : (cnt > HALF);
        all_same = (cnt == '0) || (cnt == ALL);
    end

    // Capture results only on accepted votes so idle or undefined inputs never reach the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            ones_cnt  <= '0;
            unanimous <= 1'b0;
            tie       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out       <= vote;
                ones_cnt  <= cnt;
                unanimous <= all_same;
                tie       <= is_tie;
            end
        end
    end

endmodule

// File: tb/tb_majority_voter.sv
// Scoreboard bench for majority_voter across N=3, N=4 (both tie values) and N=32.
// Stimulus pushes hand-computed expectations; per-instance monitors pop on out_valid.
// No backpressure in the design, so monitors simply compare every valid cycle.
module tb_majority_voter;

    typedef struct {
        logic       o;
        logic [5:0] c;
        logic       u;
        logic       t;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // N=3 instance
    logic [2:0]  inp3;
    logic        v3;
    logic        out3, ov3, un3, tie3;
    logic [1:0]  cnt3;

    // N=4 instances share stimulus, differ in TIE_VAL
    logic [3:0]  inp4;
    logic        v4;
    logic        out4a, ov4a, un4a, tie4a;
    logic [2:0]  cnt4a;
    logic        out4b, ov4b, un4b, tie4b;
    logic [2:0]  cnt4b;

    // N=32 instance
    logic [31:0] inp32;
    logic        v32;
    logic        out32, ov32, un32, tie32;
    logic [5:0]  cnt32;

    majority_voter #(.N(3)) d3 (
        .clk(clk), .rst(rst), .inp(inp3), .in_valid(v3),
        .out(out3), .out_valid(ov3), .ones_cnt(cnt3), .unanimous(un3), .tie(tie3)
    );

    majority_voter #(.N(4), .TIE_VAL(1'b0)) d4a (
        .clk(clk), .rst(rst), .inp(inp4), .in_valid(v4),
        .out(out4a), .out_valid(ov4a), .ones_cnt(cnt4a), .unanimous(un4a), .tie(tie4a)
    );

    majority_voter #(.N(4), .TIE_VAL(1'b1)) d4b (
        .clk(clk), .rst(rst), .inp(inp4), .in_valid(v4),
        .out(out4b), .out_valid(ov4b), .ones_cnt(cnt4b), .unanimous(un4b), .tie(tie4b)
    );

    majority_voter #(.N(32)) d32 (
        .clk(clk), .rst(rst), .inp(inp32), .in_valid(v32),
        .out(out32), .out_valid(ov32), .ones_cnt(cnt32), .unanimous(un32), .tie(tie32)
    );

    exp_t q3[$];
    exp_t q4a[$];
    exp_t q4b[$];
    exp_t q32[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic o, input logic [5:0] c,
                       input logic u, input logic t);
        chk({tag, ".out"},       {31'd0, o}, {31'd0, e.o});
        chk({tag, ".ones_cnt"},  {26'd0, c}, {26'd0, e.c});
        chk({tag, ".unanimous"}, {31'd0, u}, {31'd0, e.u});
        chk({tag, ".tie"},       {31'd0, t}, {31'd0, e.t});
    endtask

    task automatic spurious(input string tag);
        checks++;
        errors++;
        $display("FAIL %s: out_valid with no expected result pending at %0t", tag, $time);
    endtask

    function automatic exp_t mk(input logic o, input int c, input logic u, input logic t);
        exp_t e;
        e.o = o;
        e.c = 6'(c);
        e.u = u;
        e.t = t;
        return e;
    endfunction

    // Monitors: compare each presented result against the oldest pending expectation.
    always @(negedge clk) begin
        if (ov3 === 1'b1) begin
            if (q3.size() == 0) spurious("n3");
            else cmp("n3", q3.pop_front(), out3, {4'd0, cnt3}, un3, tie3);
        end
    end

    always @(negedge clk) begin
        if (ov4a === 1'b1) begin
            if (q4a.size() == 0) spurious("n4t0");
            else cmp("n4t0", q4a.pop_front(), out4a, {3'd0, cnt4a}, un4a, tie4a);
        end
    end

    always @(negedge clk) begin
        if (ov4b === 1'b1) begin
            if (q4b.size() == 0) spurious("n4t1");
            else cmp("n4t1", q4b.pop_front(), out4b, {3'd0, cnt4b}, un4b, tie4b);
        end
    end

    always @(negedge clk) begin
        if (ov32 === 1'b1) begin
            if (q32.size() == 0) spurious("n32");
            else cmp("n32", q32.pop_front(), out32, cnt32, un32, tie32);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3_zero(input string nm);
        chk({nm, ".out"},       {31'd0, out3}, 32'd0);
        chk({nm, ".out_valid"}, {31'd0, ov3},  32'd0);
        chk({nm, ".ones_cnt"},  {30'd0, cnt3}, 32'd0);
        chk({nm, ".unanimous"}, {31'd0, un3},  32'd0);
        chk({nm, ".tie"},       {31'd0, tie3}, 32'd0);
    endtask

    // Hand-computed N=3 sweep results for inp = 0..7.
    logic [7:0] sweep_out = 8'b1110_1000;   // bit i = expected out for inp=i
    logic [7:0] sweep_un  = 8'b1000_0001;
    int         sweep_cnt [8] = '{0, 1, 1, 2, 1, 2, 2, 3};

    initial begin
        rst   = 1'b1;
        inp3  = 3'b111;
        v3    = 1'b1;
        inp4  = '0;
        v4    = 1'b0;
        inp32 = '0;
        v32   = 1'b0;

        // Reset held for two cycles with a valid vote present: nothing may come out.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk3_zero("reset");
        end

        tick();
        rst = 1'b0;

        // Exhaustive N=3 sweep, back-to-back.
        for (int i = 0; i < 8; i++) begin
            inp3 = 3'(i);
            v3   = 1'b1;
            q3.push_back(mk(sweep_out[i], sweep_cnt[i], sweep_un[i], 1'b0));
            tick();
        end

        // Hold: accept 011, then idle with zero and then undefined inputs.
        inp3 = 3'b011;
        v3   = 1'b1;
        q3.push_back(mk(1'b1, 2, 1'b0, 1'b0));
        tick();
        v3   = 1'b0;
        inp3 = 3'b000;
        tick();
        @(negedge clk);
        chk("hold.out",       {31'd0, out3}, 32'd1);
        chk("hold.ones_cnt",  {30'd0, cnt3}, 32'd2);
        chk("hold.out_valid", {31'd0, ov3},  32'd0);
        inp3 = 3'bxxx;
        tick();
        @(negedge clk);
        chk("xidle.out",      {31'd0, out3}, 32'd1);
        chk("xidle.ones_cnt", {30'd0, cnt3}, 32'd2);
        chk("xidle.unanimous",{31'd0, un3},  32'd0);

        // Reset mid-stream with a concurrent valid vote: the vote is lost.
        tick();
        rst  = 1'b1;
        inp3 = 3'b110;
        v3   = 1'b1;
        tick();
        @(negedge clk);
        chk3_zero("midrst");
        rst = 1'b0;
        q3.push_back(mk(1'b1, 2, 1'b0, 1'b0));
        tick();
        v3 = 1'b0;

        // Even N=4 with both tie values.
        inp4 = 4'b0101; v4 = 1'b1;
        q4a.push_back(mk(1'b0, 2, 1'b0, 1'b1));
        q4b.push_back(mk(1'b1, 2, 1'b0, 1'b1));
        tick();
        inp4 = 4'b0111;
        q4a.push_back(mk(1'b1, 3, 1'b0, 1'b0));
        q4b.push_back(mk(1'b1, 3, 1'b0, 1'b0));
        tick();
        inp4 = 4'b1111;
        q4a.push_back(mk(1'b1, 4, 1'b1, 1'b0));
        q4b.push_back(mk(1'b1, 4, 1'b1, 1'b0));
        tick();
        inp4 = 4'b0000;
        q4a.push_back(mk(1'b0, 0, 1'b1, 1'b0));
        q4b.push_back(mk(1'b0, 0, 1'b1, 1'b0));
        tick();
        inp4 = 4'b1000;
        q4a.push_back(mk(1'b0, 1, 1'b0, 1'b0));
        q4b.push_back(mk(1'b0, 1, 1'b0, 1'b0));
        tick();
        v4 = 1'b0;

        // Large N=32.
        inp32 = 32'hFFFF_0000; v32 = 1'b1;
        q32.push_back(mk(1'b0, 16, 1'b0, 1'b1));
        tick();
        inp32 = 32'hFFFF_8000;
        q32.push_back(mk(1'b1, 17, 1'b0, 1'b0));
        tick();
        inp32 = 32'hFFFF_FFFF;
        q32.push_back(mk(1'b1, 32, 1'b1, 1'b0));
        tick();
        inp32 = 32'h0000_7FFF;
        q32.push_back(mk(1'b0, 15, 1'b0, 1'b0));
        tick();
        v32 = 1'b0;

        // Drain and make sure every expected result was actually produced.
        repeat (3) tick();
        chk("drain.n3",   q3.size(),  32'd0);
        chk("drain.n4t0", q4a.size(), 32'd0);
        chk("drain.n4t1", q4b.size(), 32'd0);
        chk("drain.n32",  q32.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/majority_voter.md
Name: majority_voter

Overview:
- Registered N-input majority voter. Output is 1 when strictly more than half of the input bits are 1.
- Default configuration is a 3-input voter: out = a&b | a&c | b&c.
- Used as a redundancy or vote block between upstream logic and consumers that need a single agreed bit.
- Also reports the ones-count and agreement flags for fault monitoring.

Parameters:
- N, 3, number of voting inputs; legal range 1..32.
- TIE_VAL, 1'b0, result driven when N is even and exactly N/2 inputs are 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inp  in  N  voting inputs, one bit per voter.
- in_valid  in  1  qualifies inp for this cycle.
- out  out  1  registered majority result.
- out_valid  out  1  high one cycle after an accepted in_valid.
- ones_cnt  out  $clog2(N+1)  registered count of 1s in the accepted inp.
- unanimous  out  1  registered; all accepted inputs equal (all 0 or all 1).
- tie  out  1  registered; even N with exactly N/2 ones (always 0 for odd N).

Behaviour:
- Reset (rst=1 at a rising edge):
  - out, out_valid, ones_cnt, unanimous and tie all become 0.
  - rst has priority over in_valid in the same cycle; that input is discarded.
- Accept:
  - On a rising edge with rst=0 and in_valid=1, compute cnt = popcount(inp).
  - Register: ones_cnt=cnt; out = (cnt > N/2), or TIE_VAL if tie; unanimous = (cnt==0 || cnt==N); tie = (N even && cnt==N/2); out_valid=1.
- Latency: exactly 1 clock from accepted input to out_valid. Throughput is one vote per cycle; back-to-back in_valid is legal.
- Idle (in_valid=0, rst=0): out_valid=0 next cycle. out, ones_cnt, unanimous and tie hold their last values.
- No backpressure: there is no ready signal and every valid input is accepted.
- Width rules:
  - ones_cnt is wide enough for the value N with no overflow.
  - The comparison uses integer N/2 (floor). For N=3, out=1 iff cnt>=2.
- N=1: out mirrors inp[0] delayed one cycle; unanimous is always 1.
- Reset mid-stream: any vote accepted in the reset cycle is lost. The first vote after reset deasserts appears one cycle after its in_valid.
- X on inp with in_valid=0 must not propagate to the outputs.

Decomposition:
- Shared package majority_pkg:
  - function cnt_width(N) = $clog2(N+1).
  - default TIE_VAL constant.
- One natural sub-module: popcount (combinational, parameter N, output cnt).
- majority_voter contains only the compare logic and the output registers.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, inp=3'b111 -> all outputs 0 and out_valid=0 throughout.
- Exhaustive sweep, N=3: inp = 0..7, one per cycle, in_valid=1.
  - out sequence: 0,0,0,1,0,1,1,1.
  - ones_cnt sequence: 0,1,1,2,1,2,2,3.
  - unanimous=1 only for 0 and 7.
  - Each result appears one cycle after its input.
- Hold, N=3: inp=3'b011 accepted, then in_valid=0 with inp=3'b000 -> out stays 1, ones_cnt stays 2, out_valid=0.
- Even N=4, TIE_VAL=0:
  - inp=4'b0101 -> tie=1, out=0, ones_cnt=2.
  - inp=4'b0111 -> out=1, tie=0.
  - Repeat with TIE_VAL=1: 4'b0101 gives out=1.
- Reset mid-stream, N=3: inp=3'b110 with in_valid=1 and rst=1 in the same cycle -> outputs stay 0. The next cycle inp=3'b110 without rst gives out=1 one cycle later.
- Large N=32: inp=32'hFFFF_0000 -> tie=1, ones_cnt=16. inp=32'hFFFF_8000 -> out=1, ones_cnt=17.
